// File: rtl/sprite_renderer.sv
// Sprite renderer: erases the previous frame's sprites, then draws the new
// ones, one registered pixel per cycle, clipped to a 640x480 screen.
module sprite_renderer #(
  parameter logic [9:0] PLANE_X      = 10'd64,
  parameter logic [2:0] BG_COLOUR    = 3'b000,
  parameter logic [2:0] PLANE_COLOUR = 3'b111,
  parameter logic [2:0] LAVA_COLOUR  = 3'b100,
  parameter logic [2:0] MTN_COLOUR   = 3'b010
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic [9:0] plane_y,
  input  logic [9:0] lava_x,
  input  logic [9:0] lava_y,
  input  logic [9:0] mountain1_x,
  input  logic [9:0] mountain1_y,
  input  logic [9:0] mountain2_x,
  input  logic [9:0] mountain2_y,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  typedef enum logic [1:0] {
    IDLE, ERASE, DRAW, FIN
  } state_t;

  state_t state_q, state_d;

  logic [1:0] obj_q, obj_d;
  logic [3:0] dx_q, dx_d;
  logic [3:0] dy_q, dy_d;

  logic [9:0] n_py_q, n_lx_q, n_ly_q;
  logic [9:0] n_ax_q, n_ay_q, n_bx_q, n_by_q;
  logic [9:0] o_py_q, o_lx_q, o_ly_q;
  logic [9:0] o_ax_q, o_ay_q, o_bx_q, o_by_q;
  logic       valid_q;

  logic [9:0] x_q, y_q;
  logic [2:0] colour_q;
  logic       plot_q, busy_q, done_q, overrun_q;

  logic        erase;
  logic [9:0]  ox, oy;
  logic [3:0]  w_last, h_last;
  logic [2:0]  col;
  logic [10:0] px, py;
  logic        on_screen, last_px, last_obj;

  assign erase = (state_q == ERASE);

  // Object geometry: erase walks the old positions, draw the new ones.
  always_comb begin
    ox     = PLANE_X;
    oy     = erase ? o_py_q : n_py_q;
    w_last = 4'd15;
    h_last = 4'd7;
    col    = PLANE_COLOUR;
    unique case (obj_q)
      2'd0: begin
        ox     = PLANE_X;
        oy     = erase ? o_py_q : n_py_q;
        w_last = 4'd15;
        h_last = 4'd7;
        col    = PLANE_COLOUR;
      end
      2'd1: begin
        ox     = erase ? o_lx_q : n_lx_q;
        oy     = erase ? o_ly_q : n_ly_q;
        w_last = 4'd7;
        h_last = 4'd7;
        col    = LAVA_COLOUR;
      end
      2'd2: begin
        ox     = erase ? o_ax_q : n_ax_q;
        oy     = erase ? o_ay_q : n_ay_q;
        w_last = 4'd15;
        h_last = 4'd15;
        col    = MTN_COLOUR;
      end
      2'd3: begin
        ox     = erase ? o_bx_q : n_bx_q;
        oy     = erase ? o_by_q : n_by_q;
        w_last = 4'd15;
        h_last = 4'd15;
        col    = MTN_COLOUR;
      end
    endcase
    if (erase) col = BG_COLOUR;
  end

  assign px        = {1'b0, ox} + {7'd0, dx_q};
  assign py        = {1'b0, oy} + {7'd0, dy_q};
  assign on_screen = (px < 11'd640) && (py < 11'd480);
  assign last_px   = (dx_q == w_last) && (dy_q == h_last);
  assign last_obj  = (obj_q == 2'd3);

  always_comb begin
    state_d = state_q;
    obj_d   = obj_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    unique case (state_q)
      IDLE: begin
        if (frame_tick) begin
          state_d = valid_q ? ERASE : DRAW;
          obj_d   = 2'd0;
          dx_d    = 4'd0;
          dy_d    = 4'd0;
        end
      end
      ERASE, DRAW: begin
        if (last_px) begin
          dx_d = 4'd0;
          dy_d = 4'd0;
          if (last_obj) begin
            obj_d   = 2'd0;
            state_d = erase ? DRAW : FIN;
          end else begin
            obj_d = obj_q + 2'd1;
          end
        end else if (dx_q == w_last) begin
          dx_d = 4'd0;
          dy_d = dy_q + 4'd1;
        end else begin
          dx_d = dx_q + 4'd1;
        end
      end
      FIN: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      obj_q     <= 2'd0;
      dx_q      <= 4'd0;
      dy_q      <= 4'd0;
      n_py_q    <= '0;
      n_lx_q    <= '0;
      n_ly_q    <= '0;
      n_ax_q    <= '0;
      n_ay_q    <= '0;
      n_bx_q    <= '0;
      n_by_q    <= '0;
      o_py_q    <= '0;
      o_lx_q    <= '0;
      o_ly_q    <= '0;
      o_ax_q    <= '0;
      o_ay_q    <= '0;
      o_bx_q    <= '0;
      o_by_q    <= '0;
      valid_q   <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= '0;
      plot_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      obj_q     <= obj_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      plot_q    <= 1'b0;
      done_q    <= (state_q == FIN);
      overrun_q <= frame_tick && (state_q != IDLE);
      if (state_q == IDLE && frame_tick) begin
        n_py_q <= plane_y;
        n_lx_q <= lava_x;
        n_ly_q <= lava_y;
        n_ax_q <= mountain1_x;
        n_ay_q <= mountain1_y;
        n_bx_q <= mountain2_x;
        n_by_q <= mountain2_y;
        busy_q <= 1'b1;
      end
      // Clipped pixels still take their cycle but leave x/y/colour as-is.
      if ((state_q == ERASE || state_q == DRAW) && on_screen) begin
        x_q      <= px[9:0];
        y_q      <= py[9:0];
        colour_q <= col;
        plot_q   <= 1'b1;
      end
      if (state_q == FIN) begin
        busy_q  <= 1'b0;
        valid_q <= 1'b1;
        o_py_q  <= n_py_q;
        o_lx_q  <= n_lx_q;
        o_ly_q  <= n_ly_q;
        o_ax_q  <= n_ax_q;
        o_ay_q  <= n_ay_q;
        o_bx_q  <= n_bx_q;
        o_by_q  <= n_by_q;
      end
    end
  end

  assign x       = x_q;
  assign y       = y_q;
  assign colour  = colour_q;
  assign plot    = plot_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// Scoreboard bench for sprite_renderer: expected pixels are queued at
// frame start and popped by a monitor on every plot strobe.
module tb_sprite_renderer;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       frame_tick = 1'b0;
  logic [9:0] plane_y = '0;
  logic [9:0] lava_x = '0;
  logic [9:0] lava_y = '0;
  logic [9:0] mountain1_x = '0;
  logic [9:0] mountain1_y = '0;
  logic [9:0] mountain2_x = '0;
  logic [9:0] mountain2_y = '0;
  logic [9:0] x, y;
  logic [2:0] colour;
  logic       plot, busy, done, overrun;

  sprite_renderer dut (
    .clk(clk),
    .resetn(resetn),
    .frame_tick(frame_tick),
    .plane_y(plane_y),
    .lava_x(lava_x),
    .lava_y(lava_y),
    .mountain1_x(mountain1_x),
    .mountain1_y(mountain1_y),
    .mountain2_x(mountain2_x),
    .mountain2_y(mountain2_y),
    .x(x),
    .y(y),
    .colour(colour),
    .plot(plot),
    .busy(busy),
    .done(done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  logic [22:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int plot_cnt = 0;
  int done_cnt = 0;
  int ov_cnt = 0;
  int rise_cyc = 0;
  int first_cyc = 0;
  bit need_first = 0;
  bit busy_p = 0;

  // Bench-side copy of what the renderer should remember between frames.
  bit vld = 0;
  int o_py, o_lx, o_ly, o_ax, o_ay, o_bx, o_by;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_obj(input int x0, input int y0, input int w,
                         input int h, input int c);
    for (int dy = 0; dy < h; dy++)
      for (int dx = 0; dx < w; dx++)
        if (x0 + dx < 640 && y0 + dy < 480)
          exp_q.push_back({10'(x0 + dx), 10'(y0 + dy), 3'(c)});
  endtask

  task automatic add_pass(input int p_y, input int lx, input int ly,
                          input int ax, input int ay, input int bx,
                          input int by, input bit era);
    add_obj(64, p_y, 16, 8, era ? 0 : 7);
    add_obj(lx, ly, 8, 8, era ? 0 : 4);
    add_obj(ax, ay, 16, 16, era ? 0 : 2);
    add_obj(bx, by, 16, 16, era ? 0 : 2);
  endtask

  task automatic set_pos(input int p_y, input int lx, input int ly,
                         input int ax, input int ay, input int bx,
                         input int by);
    plane_y     = 10'(p_y);
    lava_x      = 10'(lx);
    lava_y      = 10'(ly);
    mountain1_x = 10'(ax);
    mountain1_y = 10'(ay);
    mountain2_x = 10'(bx);
    mountain2_y = 10'(by);
  endtask

  task automatic run_frame(input string tag, input int ov_at,
                           input bit toggle);
    int c_py, c_lx, c_ly, c_ax, c_ay, c_bx, c_by;
    int q0, exp_plots, exp_busy;
    int b0, p0, d0, v0;
    bit got;
    c_py = int'(plane_y);
    c_lx = int'(lava_x);
    c_ly = int'(lava_y);
    c_ax = int'(mountain1_x);
    c_ay = int'(mountain1_y);
    c_bx = int'(mountain2_x);
    c_by = int'(mountain2_y);
    q0 = exp_q.size();
    if (vld) add_pass(o_py, o_lx, o_ly, o_ax, o_ay, o_bx, o_by, 1);
    add_pass(c_py, c_lx, c_ly, c_ax, c_ay, c_bx, c_by, 0);
    exp_plots = exp_q.size() - q0;
    exp_busy = vld ? 1409 : 705;
    b0 = busy_cnt;
    p0 = plot_cnt;
    d0 = done_cnt;
    v0 = ov_cnt;
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    got = 0;
    for (int k = 1; k < 4000; k++) begin
      frame_tick = (k == ov_at);
      if (toggle)
        set_pos($urandom_range(0, 1023), $urandom_range(0, 1023),
                $urandom_range(0, 1023), $urandom_range(0, 1023),
                $urandom_range(0, 1023), $urandom_range(0, 1023),
                $urandom_range(0, 1023));
      tick();
      if (done_cnt != d0) begin
        got = 1;
        break;
      end
    end
    frame_tick = 1'b0;
    chk({tag, " done_seen"}, int'(got), 1);
    set_pos(c_py, c_lx, c_ly, c_ax, c_ay, c_bx, c_by);
    repeat (4) tick();
    chk({tag, " busy_cycles"}, busy_cnt - b0, exp_busy);
    chk({tag, " plot_pulses"}, plot_cnt - p0, exp_plots);
    chk({tag, " done_pulses"}, done_cnt - d0, 1);
    chk({tag, " overrun_pulses"}, ov_cnt - v0, (ov_at > 0) ? 1 : 0);
    chk({tag, " first_pixel_lat"}, first_cyc - rise_cyc, 1);
    chk({tag, " queue_left"}, exp_q.size(), 0);
    chk({tag, " idle_busy"}, int'(busy), 0);
    vld = 1;
    o_py = c_py;
    o_lx = c_lx;
    o_ly = c_ly;
    o_ax = c_ax;
    o_ay = c_ay;
    o_bx = c_bx;
    o_by = c_by;
  endtask

  initial begin
    logic [22:0] e;
    bit hit;
    fork
      forever begin
        @(negedge clk);
        cyc++;
        if (busy === 1'b1) busy_cnt++;
        if (busy === 1'b1 && !busy_p) begin
          rise_cyc = cyc;
          need_first = 1;
        end
        busy_p = (busy === 1'b1);
        if (done === 1'b1) done_cnt++;
        if (overrun === 1'b1) ov_cnt++;
        if (plot === 1'b1) begin
          plot_cnt++;
          if (need_first) begin
            first_cyc = cyc;
            need_first = 0;
          end
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL pixel: unexpected plot at (%0d,%0d,%0d)",
                     x, y, colour);
          end else begin
            e = exp_q.pop_front();
            if ({x, y, colour} !== e) begin
              n_bad++;
              $display("FAIL pixel %0d: got (%0d,%0d,%0d), want (%0d,%0d,%0d)",
                       plot_cnt, x, y, colour, e[22:13], e[12:3], e[2:0]);
            end
          end
        end
      end
    join_none

    resetn = 1'b0;
    repeat (2) tick();
    chk("rst x", int'(x), 0);
    chk("rst y", int'(y), 0);
    chk("rst colour", int'(colour), 0);
    chk("rst plot", int'(plot), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst overrun", int'(overrun), 0);
    resetn = 1'b1;
    tick();

    set_pos(180, 600, 200, 400, 100, 500, 100);
    run_frame("first", 0, 0);

    plane_y = 10'd188;
    run_frame("second", 0, 0);

    mountain1_x = 10'd632;
    mountain1_y = 10'd470;
    run_frame("clip", 0, 0);

    plane_y = 10'd200;
    mountain1_x = 10'd400;
    mountain1_y = 10'd100;
    run_frame("overrun", 100, 0);

    set_pos(300, 10, 20, 30, 40, 50, 60);
    run_frame("toggle", 0, 1);

    set_pos(100, 110, 120, 130, 140, 150, 160);
    add_pass(o_py, o_lx, o_ly, o_ax, o_ay, o_bx, o_by, 1);
    add_pass(100, 110, 120, 130, 140, 150, 160, 0);
    begin
      int p0;
      p0 = plot_cnt;
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      hit = 0;
      for (int k = 0; k < 4000; k++) begin
        @(negedge clk);
        #1;
        if (plot_cnt - p0 >= 300) begin
          hit = 1;
          break;
        end
      end
      chk("midrst reached_300", int'(hit), 1);
    end
    resetn = 1'b0;
    tick();
    chk("midrst plot", int'(plot), 0);
    chk("midrst busy", int'(busy), 0);
    chk("midrst done", int'(done), 0);
    exp_q.delete();
    vld = 0;
    resetn = 1'b1;
    repeat (3) tick();
    chk("midrst stays_idle", int'(busy), 0);
    set_pos(180, 600, 200, 400, 100, 500, 100);
    run_frame("after_rst", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
